// File: rtl/line_clear.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | line_clear: finds full board rows, optionally flashes them (build with   |
// | LINE_CLEAR_FLASH_EN defined), then collapses them out of the board.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module line_clear #(
  parameter int ROWS         = 12,
  parameter int COLS         = 10,
  parameter int FLASH_CYCLES = 5_000_000,
  parameter int FLASH_PHASES = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [0:ROWS-1][COLS*4-1:0]    board_in,
  output logic [0:ROWS-1][COLS*4-1:0]    board_out,
  output logic                           busy,
  output logic                           done,
  output logic [$clog2(ROWS+1)-1:0]      lines
);

  localparam int RW = COLS * 4;
  localparam int IW = $clog2(ROWS);
  localparam int LW = $clog2(ROWS + 1);

  if (FLASH_PHASES < 2 || (FLASH_PHASES % 2) != 0 || FLASH_CYCLES < 1) begin : g_bad_params
    $error("line_clear: FLASH_PHASES must be even and >= 2, FLASH_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SCAN     = 3'd1,
`ifdef LINE_CLEAR_FLASH_EN
    S_FLASH    = 3'd2,
`endif
    S_COLLAPSE = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                     state_q, state_d;
  logic [0:ROWS-1][RW-1:0]    board_q, board_d, out_d;
  logic [ROWS-1:0]            mask_q, mask_d;
  logic [IW-1:0]              idx_q, idx_d;
  // top_q counts the rows above the collapse write pointer (write row = top_q-1)
  logic [LW-1:0]              top_q, top_d;
  logic [LW-1:0]              lines_q, lines_d;

  function automatic logic row_full(input logic [RW-1:0] row);
    row_full = 1'b1;
    for (int j = 0; j < COLS; j++)
      if (row[j*4 +: 4] == 4'h0) row_full = 1'b0;
  endfunction

`ifdef LINE_CLEAR_FLASH_EN
  localparam int CW = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam int PW = $clog2(FLASH_PHASES);
  logic [CW-1:0] cyc_q, cyc_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          flash_on;
`endif

  always_comb begin
    state_d = state_q;
    board_d = board_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    top_d   = top_q;
    lines_d = lines_q;
`ifdef LINE_CLEAR_FLASH_EN
    cyc_d    = cyc_q;
    phase_d  = phase_q;
    flash_on = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        board_d = board_in;
        if (start) begin
          state_d = S_SCAN;
          lines_d = '0;
          idx_d   = '0;
          mask_d  = '0;
        end
      end
      S_SCAN: begin
        if (row_full(board_q[idx_q])) begin
          mask_d[idx_q] = 1'b1;
          lines_d       = lines_q + 1'b1;
        end
        if (idx_q == IW'(ROWS - 1)) begin
          top_d = LW'(ROWS);
          if (mask_d == '0) begin
            state_d = S_DONE;
          end else begin
`ifdef LINE_CLEAR_FLASH_EN
            state_d = S_FLASH;
            cyc_d   = '0;
            phase_d = '0;
`else
            state_d = S_COLLAPSE;
`endif
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
`ifdef LINE_CLEAR_FLASH_EN
      S_FLASH: begin
        flash_on = ~phase_q[0];
        if (cyc_q == CW'(FLASH_CYCLES - 1)) begin
          cyc_d = '0;
          if (phase_q == PW'(FLASH_PHASES - 1)) begin
            phase_d = '0;
            state_d = S_COLLAPSE;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
`endif
      S_COLLAPSE: begin
        if (!mask_q[idx_q]) begin
          board_d[top_q - 1'b1] = board_q[idx_q];
          top_d                 = top_q - 1'b1;
        end
        if (idx_q == '0) begin
          for (int r = 0; r < ROWS; r++)
            if (LW'(r) < top_d) board_d[r] = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Overlay sits in front of the output register; the stored board is untouched.
    out_d = board_d;
`ifdef LINE_CLEAR_FLASH_EN
    if (flash_on)
      for (int r = 0; r < ROWS; r++)
        if (mask_q[r]) out_d[r] = {COLS{4'hF}};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      board_q   <= '0;
      board_out <= '0;
      mask_q    <= '0;
      idx_q     <= '0;
      top_q     <= '0;
      lines_q   <= '0;
    end else begin
      state_q   <= state_d;
      board_q   <= board_d;
      board_out <= out_d;
      mask_q    <= mask_d;
      idx_q     <= idx_d;
      top_q     <= top_d;
      lines_q   <= lines_d;
    end
  end

`ifdef LINE_CLEAR_FLASH_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q   <= '0;
      phase_q <= '0;
    end else begin
      cyc_q   <= cyc_d;
      phase_q <= phase_d;
    end
  end
`endif

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  assign lines = lines_q;

endmodule
`default_nettype wire
